// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I-subset core.
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, with an absorbing HALT.
//   Ports:
//     clk, rst                    clock, asynchronous active-low reset
//     opcode/funct3/funct7b5, eq  instruction fields and ALU equality flag
//     imem_ack, dmem_ack          memory completion strobes
//     imem_req, dmem_req, dmem_we memory requests and store enable
//     ir_we, pc_we, pcsrc, regwrite, alusrc, resultsrc, aluctrl, immsrc
//                                 datapath strobes and selects
//     state, halted, err, instret FSM state, halt flag, error code, retired count
//   Build option: define MEM_TIMEOUT_EN to enable the memory-ack watchdog
//   (TIMEOUT pending cycles -> HALT with err=10).
module multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        eq,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pcsrc,
  output logic        regwrite,
  output logic        alusrc,
  output logic        resultsrc,
  output logic [2:0]  aluctrl,
  output logic [2:0]  immsrc,
  output logic [2:0]  state,
  output logic        halted,
  output logic [1:0]  err,
  output logic [31:0] instret
);

  localparam int WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t         cur, nxt;
  logic           set_ill, set_to;
  logic           pending, wd_en, wd_lim, wd_hit;
  logic [WDW-1:0] wd_cnt;

  // Instruction class decode
  logic is_r, is_i, is_ld, is_st, is_br, legal;
  assign is_r  = (opcode == 7'b0110011);
  assign is_i  = (opcode == 7'b0010011);
  assign is_ld = (opcode == 7'b0000011);
  assign is_st = (opcode == 7'b0100011);
  assign is_br = (opcode == 7'b1100011) && (funct3[2:1] == 2'b00);
  assign legal = is_r | is_i | is_ld | is_st | is_br;

`ifdef MEM_TIMEOUT_EN
  assign wd_en = 1'b1;
`else
  assign wd_en = 1'b0;
`endif

  // A request is pending when it is driven and not acknowledged this cycle.
  assign pending = ((cur == S_FETCH) && !imem_ack) || ((cur == S_MEM) && !dmem_ack);
  assign wd_lim  = (wd_cnt == WDW'(TIMEOUT - 1));
  assign wd_hit  = wd_en && pending && wd_lim;

  assign state = cur;

  always_comb begin
    nxt       = cur;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pcsrc     = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 1'b0;
    alusrc    = 1'b0;
    immsrc    = 3'b000;
    aluctrl   = 3'b000;
    halted    = 1'b0;
    set_ill   = 1'b0;
    set_to    = 1'b0;

    // Selects follow the instruction register in every live state.
    if (cur != S_HALT) begin
      alusrc = is_i | is_ld | is_st;
      if (is_st)      immsrc = 3'b001;
      else if (is_br) immsrc = 3'b010;
      if (is_br) aluctrl = 3'b001;
      else if (is_r || is_i) begin
        case (funct3)
          3'b000:  aluctrl = (is_r && funct7b5) ? 3'b001 : 3'b000;
          3'b111:  aluctrl = 3'b010;
          3'b110:  aluctrl = 3'b011;
          3'b010:  aluctrl = 3'b101;
          default: aluctrl = 3'b000;
        endcase
      end
    end

    case (cur)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) nxt = S_EXEC;
        else begin
          nxt     = S_HALT;
          set_ill = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_r || is_i)        nxt = S_WB;
        else if (is_ld || is_st) nxt = S_MEM;
        else if (is_br) begin
          pc_we = 1'b1;
          pcsrc = funct3[0] ? !eq : eq;
          nxt   = S_FETCH;
        end else begin
          // Instruction register changed under us: treat as illegal.
          nxt     = S_HALT;
          set_ill = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        if (dmem_ack) begin
          if (is_st) begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end else nxt = S_WB;
        end
      end
      S_WB: begin
        regwrite  = 1'b1;
        resultsrc = is_ld;
        pc_we     = 1'b1;
        nxt       = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: nxt = S_HALT;
    endcase

    if (wd_hit) begin
      nxt    = S_HALT;
      set_to = 1'b1;
    end

    // Requests and strobes drop as soon as reset is asserted, not at the next edge.
    if (!rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      ir_we    = 1'b0;
      pc_we    = 1'b0;
      regwrite = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= S_FETCH;
      err     <= 2'b00;
      instret <= 32'd0;
      wd_cnt  <= '0;
    end else begin
      cur <= nxt;
      if (set_to)       err <= 2'b10;
      else if (set_ill) err <= 2'b01;
      if (pc_we) instret <= instret + 32'd1;
      // Any state change (entry to FETCH/MEM included) restarts the watchdog.
      if (nxt != cur)             wd_cnt <= '0;
      else if (pending && !wd_lim) wd_cnt <= wd_cnt + WDW'(1);
    end
  end

endmodule
